// File: rtl/pps_timekeeper.sv
// pps_timekeeper: PPS-disciplined time-of-day clock with acquire/lock tracking.
// Define PPS_HOLDOVER_EN to free-run through PPS loss (HOLDOVER) instead of dropping straight to UNLOCKED.
module pps_timekeeper #(
    parameter int CLK_HZ   = 50000000,
    parameter int TOL      = 5000,
    parameter int LOCK_N   = 3,
    parameter int HOLD_MAX = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pe,
    input  logic        load,
    input  logic [4:0]  load_hour,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_sec,
    output logic        tick,
    output logic [4:0]  hour,
    output logic [5:0]  min,
    output logic [5:0]  sec,
    output logic        locked,
    output logic        holdover,
    output logic [31:0] period
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, HOLDOVER} state_t;
    localparam logic [32:0] LO = 33'(CLK_HZ - TOL);
    localparam logic [32:0] HI = 33'(CLK_HZ + TOL);
    localparam int GW = $clog2(LOCK_N + 1);
    state_t state, state_n;
    logic [31:0] cyc;
    logic [32:0] ival;
    logic [GW-1:0] good_cnt;
    logic in_tol, tmo, tick_d, cyc_clr, cyc_hold, good_clr, good_inc, per_ld, load_ok;
    logic [4:0] hour_n;
    logic [5:0] min_n, sec_n;
`ifdef PPS_HOLDOVER_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    logic [HW-1:0] hold_cnt;
    logic hold_set, hold_inc;
`endif
    assign ival   = {1'b0, cyc} + 33'd1;
    assign in_tol = ival >= LO && ival <= HI;
    assign tmo    = !pe && ival >= HI;
    assign locked = state == LOCKED;
`ifdef PPS_HOLDOVER_EN
    assign holdover = state == HOLDOVER;
`else
    assign holdover = 1'b0;
`endif
    always_comb begin
        state_n  = state;
        tick_d   = 1'b0;
        cyc_clr  = 1'b0;
        cyc_hold = 1'b0;
        good_clr = 1'b0;
        good_inc = 1'b0;
        per_ld   = 1'b0;
`ifdef PPS_HOLDOVER_EN
        hold_set = 1'b0;
        hold_inc = 1'b0;
`endif
        case (state)
            UNLOCKED: if (pe) begin
                state_n  = ACQUIRE;
                cyc_clr  = 1'b1;
                good_clr = 1'b1;
            end
            ACQUIRE: if (pe) begin
                cyc_clr  = 1'b1;
                tick_d   = in_tol;
                per_ld   = in_tol;
                good_inc = in_tol;
                good_clr = !in_tol;
                if (in_tol && good_cnt == GW'(LOCK_N - 1)) state_n = LOCKED;
            end else if (tmo) state_n = UNLOCKED;
            LOCKED: if (pe && in_tol) begin
                tick_d  = 1'b1;
                cyc_clr = 1'b1;
                per_ld  = 1'b1;
            end else if (tmo) begin
`ifdef PPS_HOLDOVER_EN
                state_n  = HOLDOVER;
                tick_d   = 1'b1;
                cyc_hold = 1'b1;
                hold_set = 1'b1;
`else
                state_n  = UNLOCKED;
`endif
            end
            default: begin
`ifdef PPS_HOLDOVER_EN
                // A PPS edge pre-empts any free-run tick falling in the same cycle
                if (pe) begin
                    state_n  = ACQUIRE;
                    cyc_clr  = 1'b1;
                    good_clr = 1'b1;
                end else if (ival == {1'b0, period}) begin
                    tick_d   = 1'b1;
                    cyc_clr  = 1'b1;
                    hold_inc = 1'b1;
                    if (hold_cnt == HW'(HOLD_MAX - 1)) state_n = UNLOCKED;
                end
`else
                state_n = UNLOCKED;
`endif
            end
        endcase
    end
    assign load_ok = load_hour < 5'd24 && load_min < 6'd60 && load_sec < 6'd60;
    assign sec_n   = sec == 6'd59 ? 6'd0 : sec + 6'd1;
    assign min_n   = sec != 6'd59 ? min : (min == 6'd59 ? 6'd0 : min + 6'd1);
    assign hour_n  = (sec != 6'd59 || min != 6'd59) ? hour : (hour == 5'd23 ? 5'd0 : hour + 5'd1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            cyc      <= '0;
            good_cnt <= '0;
            period   <= 32'(CLK_HZ);
            tick     <= 1'b0;
            hour     <= '0;
            min      <= '0;
            sec      <= '0;
        end else begin
            state    <= state_n;
            tick     <= tick_d;
            cyc      <= cyc_clr ? '0 : cyc_hold ? HI[31:0] - period : (cyc == '1 ? cyc : cyc + 32'd1);
            good_cnt <= good_clr ? '0 : good_inc ? good_cnt + GW'(1) : good_cnt;
            period   <= per_ld ? ival[31:0] : period;
            if (load && load_ok) begin
                hour <= load_hour;
                min  <= load_min;
                sec  <= load_sec;
            end else if (tick_d) begin
                hour <= hour_n;
                min  <= min_n;
                sec  <= sec_n;
            end
        end
    end
`ifdef PPS_HOLDOVER_EN
    always_ff @(posedge clk) begin
        if (rst) hold_cnt <= '0;
        else hold_cnt <= hold_set ? HW'(1) : hold_inc ? hold_cnt + HW'(1) : hold_cnt;
    end
`endif
endmodule

// File: tb/tb_pps_timekeeper.sv
// tb_pps_timekeeper: directed checks of lock acquisition, glitch rejection, PPS loss, time load and reset.
module tb_pps_timekeeper;
    logic clk = 1'b0, rst = 1'b1, pe = 1'b0, load = 1'b0;
    logic [4:0] load_hour = '0;
    logic [5:0] load_min = '0, load_sec = '0;
    logic tick, locked, holdover;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic [31:0] period;
    int tests = 0, fails = 0, tick_cnt = 0;

    pps_timekeeper #(.CLK_HZ(100), .TOL(5), .LOCK_N(3), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .pe(pe), .load(load), .load_hour(load_hour), .load_min(load_min),
        .load_sec(load_sec), .tick(tick), .hour(hour), .min(min), .sec(sec), .locked(locked),
        .holdover(holdover), .period(period)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (tick) tick_cnt++;
    endtask

    // Assumes the previous PPS edge was just sampled; the new pe is sampled with interval gap.
    task automatic send_pe(input int gap, input bit ld, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        pe = 1'b0;
        repeat (gap - 1) step();
        pe = 1'b1;
        load = ld;
        load_hour = h;
        load_min = m;
        load_sec = s;
        step();
        pe = 1'b0;
        load = 1'b0;
    endtask

    task automatic check_idle(input string name);
        tests++;
        if ({tick, locked, holdover, hour, min, sec, period} !== {3'b000, 5'd0, 6'd0, 6'd0, 32'd100}) begin
            fails++;
            $display("FAIL %s: tick=%0b locked=%0b holdover=%0b time=%0d:%0d:%0d period=%0d, want 0 0 0 0:0:0 100",
                     name, tick, locked, holdover, hour, min, sec, period);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
    endtask

    task automatic test_acquire();
        int t0;
        send_pe(100, 0, 0, 0, 0);
        tests++;
        if (tick !== 1'b0 || locked !== 1'b0) begin
            fails++;
            $display("FAIL acq_first: tick=%0b locked=%0b, want 0 0", tick, locked);
        end
        t0 = tick_cnt;
        for (int i = 2; i <= 4; i++) begin
            send_pe(100, 0, 0, 0, 0);
            tests++;
            if (tick !== 1'b1 || locked !== (i == 4)) begin
                fails++;
                $display("FAIL acq_pe%0d: tick=%0b locked=%0b, want 1 %0b", i, tick, locked, i == 4);
            end
        end
        tests++;
        if (tick_cnt - t0 !== 3 || sec !== 6'd3 || period !== 32'd100) begin
            fails++;
            $display("FAIL acq_summary: ticks=%0d sec=%0d period=%0d, want 3 3 100", tick_cnt - t0, sec, period);
        end
    endtask

    task automatic test_glitch();
        send_pe(98, 0, 0, 0, 0);
        tests++;
        if (tick !== 1'b1 || period !== 32'd98 || sec !== 6'd4) begin
            fails++;
            $display("FAIL glitch_98: tick=%0b period=%0d sec=%0d, want 1 98 4", tick, period, sec);
        end
        send_pe(40, 0, 0, 0, 0);
        tests++;
        if (tick !== 1'b0 || locked !== 1'b1 || period !== 32'd98) begin
            fails++;
            $display("FAIL glitch_40: tick=%0b locked=%0b period=%0d, want 0 1 98", tick, locked, period);
        end
        send_pe(60, 0, 0, 0, 0);
        tests++;
        if (tick !== 1'b1 || period !== 32'd100 || sec !== 6'd5) begin
            fails++;
            $display("FAIL glitch_after: tick=%0b period=%0d sec=%0d, want 1 100 5", tick, period, sec);
        end
    endtask

    task automatic test_pps_loss();
        int t0 = tick_cnt;
        pe = 1'b0;
`ifdef PPS_HOLDOVER_EN
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 104 || k == 105 || k == 199 || k == 200 || k == 300 || k == 400) begin
                tests++;
                if (tick !== (k != 104 && k != 199) || holdover !== (k >= 105 && k < 400) || locked !== (k < 105)) begin
                    fails++;
                    $display("FAIL loss_k%0d: tick=%0b holdover=%0b locked=%0b", k, tick, holdover, locked);
                end
            end
        end
        tests++;
        if (tick_cnt - t0 !== 4 || sec !== 6'd9) begin
            fails++;
            $display("FAIL loss_count: ticks=%0d sec=%0d, want 4 9", tick_cnt - t0, sec);
        end
`else
        for (int k = 1; k <= 105; k++) begin
            step();
            if (k >= 104) begin
                tests++;
                if (tick !== 1'b0 || holdover !== 1'b0 || locked !== (k == 104)) begin
                    fails++;
                    $display("FAIL loss_k%0d: tick=%0b holdover=%0b locked=%0b", k, tick, holdover, locked);
                end
            end
        end
        tests++;
        if (tick_cnt - t0 !== 0 || sec !== 6'd5) begin
            fails++;
            $display("FAIL loss_count: ticks=%0d sec=%0d, want 0 5", tick_cnt - t0, sec);
        end
`endif
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) send_pe(i == 3 ? 97 : 100, 0, 0, 0, 0);
        load = 1'b1;
        load_hour = 5'd23;
        load_min = 6'd59;
        load_sec = 6'd59;
        step();
        load = 1'b0;
        tests++;
        if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59} || locked !== 1'b1 || period !== 32'd97) begin
            fails++;
            $display("FAIL load_set: time=%0d:%0d:%0d locked=%0b period=%0d, want 23:59:59 1 97", hour, min, sec, locked, period);
        end
        send_pe(99, 0, 0, 0, 0);
        tests++;
        if ({hour, min, sec} !== 17'd0 || tick !== 1'b1) begin
            fails++;
            $display("FAIL load_wrap: time=%0d:%0d:%0d tick=%0b, want 0:0:0 1", hour, min, sec, tick);
        end
        send_pe(103, 1, 5'd12, 6'd0, 6'd0);
        tests++;
        if ({hour, min, sec} !== {5'd12, 6'd0, 6'd0} || tick !== 1'b1 || period !== 32'd103) begin
            fails++;
            $display("FAIL load_tick: time=%0d:%0d:%0d tick=%0b period=%0d, want 12:0:0 1 103", hour, min, sec, tick, period);
        end
        load = 1'b1;
        load_hour = 5'd1;
        load_min = 6'd2;
        load_sec = 6'd60;
        step();
        load_sec = 6'd3;
        load_hour = 5'd24;
        step();
        load = 1'b0;
        tests++;
        if ({hour, min, sec} !== {5'd12, 6'd0, 6'd0}) begin
            fails++;
            $display("FAIL load_bad: time=%0d:%0d:%0d, want 12:0:0", hour, min, sec);
        end
    endtask

    task automatic test_reset_mid();
`ifdef PPS_HOLDOVER_EN
        pe = 1'b0;
        repeat (120) step();
        tests++;
        if (holdover !== 1'b1) begin
            fails++;
            $display("FAIL mid_hold: holdover=%0b, want 1", holdover);
        end
`else
        pe = 1'b0;
        repeat (50) step();
`endif
        rst = 1'b1;
        pe = 1'b1;
        load = 1'b1;
        load_hour = 5'd3;
        load_min = 6'd4;
        load_sec = 6'd5;
        step();
        rst = 1'b0;
        pe = 1'b0;
        load = 1'b0;
        check_idle("reset_mid");
        send_pe(10, 0, 0, 0, 0);
        tests++;
        if (tick !== 1'b0 || locked !== 1'b0 || holdover !== 1'b0) begin
            fails++;
            $display("FAIL after_rst_pe1: tick=%0b locked=%0b holdover=%0b, want 0 0 0", tick, locked, holdover);
        end
        send_pe(100, 0, 0, 0, 0);
        tests++;
        if (tick !== 1'b1 || locked !== 1'b0 || sec !== 6'd1) begin
            fails++;
            $display("FAIL after_rst_pe2: tick=%0b locked=%0b sec=%0d, want 1 0 1", tick, locked, sec);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_glitch();
        test_pps_loss();
        test_load();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
